// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, one transaction in flight.
// A watchdog force-completes unacknowledged transactions with ERR_DATA and logs the fault.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        timeout_irq,
    output logic [31:0] err_addr,
    output logic        err_master
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q;
    logic              gnt_q;
    logic              last_q;
    logic [CntW-1:0]   cnt_q;
    logic              timeout_irq_q;
    logic [31:0]       err_addr_q;
    logic              err_master_q;

    logic              mgnt_valid;
    logic [3:0]        mgnt_wstrb;
    logic [31:0]       mgnt_addr;
    logic [31:0]       mgnt_wdata;
    logic              busy;
    logic              active;
    logic              expired;
    logic              done;
    logic              winner;

    always_comb begin
        mgnt_valid = gnt_q ? m1_valid : m0_valid;
        mgnt_wstrb = gnt_q ? m1_wstrb : m0_wstrb;
        mgnt_addr  = gnt_q ? m1_addr  : m0_addr;
        mgnt_wdata = gnt_q ? m1_wdata : m0_wdata;
        busy       = (state_q == StBusy);
        active     = busy && mgnt_valid;
        // A slave ack in the final watchdog cycle takes precedence over the timeout.
        expired    = active && !s_ready && (cnt_q == CntW'(TIMEOUT - 1));
        done       = active && (s_ready || expired);
        winner     = (m0_valid && m1_valid) ? !last_q : m1_valid;
    end

    always_comb begin
        s_valid  = active && !expired;
        s_wstrb  = busy ? mgnt_wstrb : 4'h0;
        s_addr   = busy ? mgnt_addr  : m0_addr;
        s_wdata  = busy ? mgnt_wdata : m0_wdata;
        m0_ready = done && !gnt_q;
        m1_ready = done && gnt_q;
        m0_rdata = (expired && !gnt_q) ? ERR_DATA : s_rdata;
        m1_rdata = (expired && gnt_q)  ? ERR_DATA : s_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            cnt_q         <= '0;
            timeout_irq_q <= 1'b0;
            err_addr_q    <= 32'h0;
            err_master_q  <= 1'b0;
        end else begin
            timeout_irq_q <= expired;
            case (state_q)
                StIdle: begin
                    if (m0_valid || m1_valid) begin
                        gnt_q   <= winner;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!mgnt_valid) begin
                        // Master withdrew its request: abandon without completion.
                        state_q <= StIdle;
                    end else if (done) begin
                        last_q  <= gnt_q;
                        state_q <= StIdle;
                        if (expired) begin
                            err_addr_q   <= mgnt_addr;
                            err_master_q <= gnt_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign timeout_irq = timeout_irq_q;
    assign err_addr    = err_addr_q;
    assign err_master  = err_master_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_bus_arbiter;

    localparam int unsigned TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout_irq, err_master;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 1000;

    mem_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR_VAL)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .timeout_irq(timeout_irq), .err_addr(err_addr), .err_master(err_master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: acks the ack_delay-th cycle (0-based) of a continuous s_valid run.
    // s_ready is raised tentatively first because the watchdog masks s_valid when it is low.
    initial begin
        int s_cnt;
        s_cnt   = 0;
        s_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            s_ready = (s_cnt == ack_delay);
            #1;
            if (s_valid === 1'b1) begin
                s_cnt++;
            end else begin
                s_ready = 1'b0;
                s_cnt   = 0;
            end
        end
    end

    // Reference model: who owns the bus, how many busy cycles it has used, and the error log.
    bit          md_busy, md_owner, md_last, md_irq, md_err_master;
    int          md_age;
    logic [31:0] md_err_addr;

    initial begin
        bit          req, exp_expired, exp_done;
        logic [31:0] own_addr;
        forever begin
            @(negedge clk);
            if (reset) begin
                md_busy = 0; md_owner = 0; md_last = 1; md_age = 0;
                md_irq = 0; md_err_addr = 32'h0; md_err_master = 0;
            end
            req         = md_busy && (md_owner ? m1_valid : m0_valid);
            own_addr    = md_owner ? m1_addr : m0_addr;
            exp_expired = req && !s_ready && (md_age == TO - 1);
            exp_done    = req && (s_ready || exp_expired);
            check("mdl_s_valid", s_valid, req && !exp_expired);
            check("mdl_s_addr", s_addr, md_busy ? own_addr : m0_addr);
            check("mdl_s_wdata", s_wdata,
                  md_busy ? (md_owner ? m1_wdata : m0_wdata) : m0_wdata);
            check("mdl_s_wstrb", s_wstrb, md_busy ? (md_owner ? m1_wstrb : m0_wstrb) : 4'h0);
            check("mdl_m0_ready", m0_ready, exp_done && !md_owner);
            check("mdl_m1_ready", m1_ready, exp_done && md_owner);
            if (exp_done)
                check("mdl_rdata", md_owner ? m1_rdata : m0_rdata,
                      exp_expired ? ERR_VAL : s_rdata);
            check("mdl_irq", timeout_irq, md_irq);
            check("mdl_err_addr", err_addr, md_err_addr);
            check("mdl_err_master", err_master, md_err_master);
            if (!reset) begin
                md_irq = exp_expired;
                if (exp_expired) begin
                    md_err_addr   = own_addr;
                    md_err_master = md_owner;
                end
                if (!md_busy) begin
                    if (m0_valid || m1_valid) begin
                        md_owner = (m0_valid && m1_valid) ? !md_last : m1_valid;
                        md_busy  = 1;
                        md_age   = 0;
                    end
                end else if (!req) begin
                    md_busy = 0;
                end else if (exp_done) begin
                    md_busy = 0;
                    md_last = md_owner;
                end else begin
                    md_age++;
                end
            end
        end
    end

    task automatic wait_ready(input bit m, input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((m ? m1_ready : m0_ready) === 1'b1) begin
                at = c;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          at;
        int          got;
        logic [31:0] seen_addr[4];
        bit          seen_m1[4];
        int          seen_cyc[4];

        reset = 1'b1;
        m0_valid = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
        s_rdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_s_valid", s_valid, 0);
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_irq", timeout_irq, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_master", err_master, 0);

        // Single m0 read, slave acks two cycles after s_valid.
        @(posedge clk); #1;
        ack_delay = 2; s_rdata = 32'h1234_5678;
        m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0; m0_wdata = 32'h1111_2222;
        @(negedge clk); check("t1_idle_s_valid", s_valid, 0);
        @(negedge clk); check("t1_s_valid", s_valid, 1); check("t1_s_addr", s_addr, 32'h100);
        @(negedge clk); check("t1_wait_ready", m0_ready, 0);
        @(negedge clk);
        check("t1_m0_ready", m0_ready, 1);
        check("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        check("t1_m1_ready", m1_ready, 0);
        @(posedge clk); #1 m0_valid = 0;

        // Both masters requesting from reset: strict alternation with an idle gap.
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        ack_delay = 1; s_rdata = 32'hA5A5_0000;
        m0_valid = 1; m0_addr = 32'h0000_1000; m0_wdata = 32'h0101_0101; m0_wstrb = 4'h1;
        m1_valid = 1; m1_addr = 32'h0000_2000; m1_wdata = 32'h0202_0202; m1_wstrb = 4'h3;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                seen_addr[got] = s_addr;
                seen_m1[got]   = m1_ready;
                seen_cyc[got]  = c;
                got++;
            end
        end
        @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
        check("t2_count", got, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_grant", seen_m1[i], i % 2);
            check("t2_addr", seen_addr[i], (i % 2) ? 32'h2000 : 32'h1000);
            check("t2_cycle", seen_cyc[i], 2 + 3 * i);
        end

        // m1 write with no slave ack: watchdog completes it.
        @(posedge clk); #1;
        ack_delay = 1000; s_rdata = 32'h0;
        m1_valid = 1; m1_addr = 32'h0400_0000; m1_wstrb = 4'hF; m1_wdata = 32'h55AA_55AA;
        wait_ready(1, 30, at);
        check("t3_latency", at, 8);
        check("t3_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("t3_s_valid_masked", s_valid, 0);
        @(posedge clk); #1 m1_valid = 0;
        @(negedge clk);
        check("t3_irq", timeout_irq, 1);
        check("t3_err_addr", err_addr, 32'h0400_0000);
        check("t3_err_master", err_master, 1);
        @(negedge clk); check("t3_irq_pulse", timeout_irq, 0);

        // Slave acks in the last watchdog cycle: normal completion wins.
        @(posedge clk); #1;
        ack_delay = 7; s_rdata = 32'hCAFE_F00D;
        m0_valid = 1; m0_addr = 32'h0000_3000; m0_wstrb = 4'h0;
        wait_ready(0, 30, at);
        check("t4_latency", at, 8);
        check("t4_m0_rdata", m0_rdata, 32'hCAFE_F00D);
        check("t4_s_valid", s_valid, 1);
        @(posedge clk); #1 m0_valid = 0;
        @(negedge clk);
        check("t4_irq", timeout_irq, 0);
        check("t4_err_addr", err_addr, 32'h0400_0000);
        check("t4_err_master", err_master, 1);

        // Reset during a busy m0 transaction.
        @(posedge clk); #1;
        ack_delay = 1000;
        m0_valid = 1; m0_addr = 32'h0000_5000;
        repeat (3) @(negedge clk);
        check("t5_busy", s_valid, 1);
        @(posedge clk); #1;
        reset = 1; ack_delay = 1; s_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        check("t5_rst_s_valid", s_valid, 0);
        check("t5_rst_m0_ready", m0_ready, 0);
        check("t5_rst_err_addr", err_addr, 0);
        check("t5_rst_err_master", err_master, 0);
        @(posedge clk); #1 reset = 0;
        wait_ready(0, 10, at);
        check("t5_regrant_latency", at, 2);
        check("t5_m0_rdata", m0_rdata, 32'h0BAD_CAFE);
        @(posedge clk); #1 m0_valid = 0;

        // m0 withdraws mid-transaction; m1 then served normally.
        @(posedge clk); #1;
        ack_delay = 1000;
        m0_valid = 1; m0_addr = 32'h0000_6000;
        @(negedge clk);
        @(negedge clk); check("t6_busy", s_valid, 1);
        @(posedge clk); #1 m0_valid = 0;
        @(negedge clk);
        check("t6_drop_s_valid", s_valid, 0);
        check("t6_drop_m0_ready", m0_ready, 0);
        @(negedge clk); check("t6_no_irq", timeout_irq, 0);
        @(posedge clk); #1;
        ack_delay = 1; s_rdata = 32'h7777_0001;
        m1_valid = 1; m1_addr = 32'h0000_7000; m1_wstrb = 4'h0;
        wait_ready(1, 10, at);
        check("t6_m1_latency", at, 2);
        check("t6_m1_rdata", m1_rdata, 32'h7777_0001);
        check("t6_m0_ready", m0_ready, 0);
        @(posedge clk); #1 m1_valid = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the native memory bus (valid/ready/wstrb/addr/wdata/rdata), sitting between the masters and the SoC address decoder.
- m0 is the CPU; m1 is a future DMA/debug master. Both share one slave port.
- Round-robin grant with one transaction in flight.
- A bus watchdog completes any transaction that no slave acknowledges. It returns ERR_DATA, pulses an interrupt line and captures the faulting address.

Parameters:
- TIMEOUT, 256, cycles in BUSY without s_ready before forced completion (range 2..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- m0_valid  input  1  master 0 request
- m0_ready  output  1  master 0 transaction complete
- m0_wstrb  input  4  master 0 byte write strobes (0 = read)
- m0_addr  input  32  master 0 address
- m0_wdata  input  32  master 0 write data
- m0_rdata  output  32  master 0 read data
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: same as m0, for master 1
- s_valid  output  1  request to decoder
- s_ready  input  1  decoder/slave acknowledge
- s_wstrb  output  4  forwarded strobes
- s_addr  output  32  forwarded address
- s_wdata  output  32  forwarded write data
- s_rdata  input  32  slave read data
- timeout_irq  output  1  one-cycle pulse on forced completion
- err_addr  output  32  address of last timed-out transaction
- err_master  output  1  master index of last timed-out transaction

Behaviour:
- Registered state: state {IDLE, BUSY}, gnt (1 bit), last (1 bit), cnt ($clog2(TIMEOUT+1) bits), timeout_irq, err_addr, err_master.
- Reset (async assert, sync release) values:
  - state=IDLE, gnt=0, last=1 (so m0 wins the first tie), cnt=0.
  - timeout_irq=0, err_addr=0, err_master=0.
  - All m*_ready=0, s_valid=0.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant that master.
  - Both valid: grant !last.
  - On grant: gnt<=winner, cnt<=0, state<=BUSY. No slave request is issued in the IDLE cycle.
- BUSY, slave-side outputs:
  - s_valid = mgnt_valid.
  - s_addr/s_wdata/s_wstrb are muxed from the granted master.
  - In IDLE, s_wstrb is forced to 0; s_addr/s_wdata follow m0.
- BUSY, completion by slave:
  - If s_ready: mgnt_ready=1 and mgnt_rdata=s_rdata in the same cycle (combinational).
  - Then last<=gnt, state<=IDLE.
- BUSY, timeout:
  - If !s_ready and cnt==TIMEOUT-1:
    - mgnt_ready=1, mgnt_rdata=ERR_DATA, s_valid forced 0 this cycle.
    - timeout_irq<=1 for exactly one cycle.
    - err_addr<=mgnt_addr, err_master<=gnt.
    - last<=gnt, state<=IDLE.
  - The write is dropped.
- BUSY, otherwise: cnt<=cnt+1.
- BUSY, protocol violation: if the granted master deasserts valid, go to IDLE with no ready and no irq.
- m*_ready of the non-granted master is always 0. m*_rdata = s_rdata when not granted (don't-care).
- Latency: a request accepted in IDLE cycle N drives s_valid in cycle N+1. Ready returns in the same cycle the slave acks. There is a minimum one idle cycle between back-to-back transactions.
- Simultaneous s_ready and timeout condition: s_ready wins; normal completion, no irq, err_* unchanged.
- Fairness: with both masters continuously requesting, grants alternate strictly m0, m1, m0, ...
- Reset mid-transaction: immediate return to IDLE. Outputs take reset values and err_* is cleared. The master must reissue.
- cnt never wraps: it is cleared on every grant and saturation is unreachable past TIMEOUT-1.

Test Plan:
- m0 read addr 0x0000_0100; slave acks 2 cycles after s_valid with rdata 0x1234_5678 -> s_valid rises one cycle after m0_valid; m0_ready=1 with m0_rdata=0x1234_5678 in the ack cycle; m1_ready stays 0.
- m0 and m1 both valid from reset, slave acks each request after 1 cycle, 4 transactions -> grant order m0, m1, m0, m1; s_addr alternates accordingly; one idle cycle between transactions.
- m1 write 0x0400_0000, wstrb=4'hF, no slave ack, TIMEOUT=8 -> m1_ready=1 exactly 8 cycles after entering BUSY, m1_rdata=0xDEAD_BEEF; timeout_irq high 1 cycle; err_addr=0x0400_0000; err_master=1.
- TIMEOUT=8, s_ready asserted on the 8th BUSY cycle -> normal completion with s_rdata; timeout_irq=0; err_addr keeps its previous value.
- Assert reset for 1 cycle during a BUSY m0 transaction with err_addr=0x0400_0000 -> s_valid=0 and m0_ready=0 immediately; err_addr=0; after release, m0 still valid -> re-granted, transaction completes normally.
- m0 requests then drops m0_valid after 1 BUSY cycle -> state returns to IDLE; no m0_ready; no timeout_irq; subsequent m1 request granted normally.
